// File: rtl/spi_minion_pkg.sv
// Shared types and sizing helpers for the SPI minion frame interface.
package spi_minion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  localparam int NBITS_DEFAULT = 32;
  localparam int SYNC_DEFAULT  = 2;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_pad_sync.sv
// Multi-flop synchroniser for an asynchronous pad input, with edge strobes
// derived from the synced value and a one-cycle delayed copy.
module spi_pad_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      q_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_minion_frame_if.sv
// SPI mode-0 minion: one NBITS word in on mosi and one out on miso per
// chip-select frame, bridged to val/rdy streams toward the FFT core.
//
// state | meaning
// IDLE  | waiting for cs to fall
// SHIFT | exchanging bits on synced sclk edges
// DONE  | full word received, ignoring sclk until cs rises
module spi_minion_frame_if
  import spi_minion_pkg::*;
#(
  parameter int NBITS       = NBITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic             overflow,
  output logic             underflow
);

  localparam int CNT_W = cnt_width(NBITS);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_s_unused, sclk_s_unused;

  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_pad_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign cs_s_unused   = cs_s;
  assign sclk_s_unused = sclk_s;

  spi_state_e       state, state_nx;
  logic [CNT_W-1:0] bit_cnt;
  logic [NBITS-1:0] rx_shift, tx_shift;
  logic             start, abort, rx_step, tx_step, last_bit, push_pend;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // cs_rise is checked first in SHIFT so a coincident sclk_rise never shifts.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    abort    = 1'b0;
    rx_step  = 1'b0;
    tx_step  = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        start    = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_step = 1'b1;
            if (bit_cnt == CNT_W'(NBITS - 1)) begin
              last_bit = 1'b1;
              state_nx = DONE;
            end
          end
          if (sclk_fall) tx_step = 1'b1;
        end
      end
      DONE: if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign send_rdy = start & send_val;
  assign miso     = (state != IDLE) & tx_shift[NBITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      push_pend <= 1'b0;
      recv_msg  <= '0;
      recv_val  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (start) begin
        bit_cnt  <= '0;
        tx_shift <= send_val ? send_msg : '0;
        if (!send_val) underflow <= 1'b1;
      end
      if (abort) bit_cnt <= '0;
      if (rx_step) begin
        rx_shift <= {rx_shift[NBITS-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (tx_step) tx_shift <= {tx_shift[NBITS-2:0], 1'b0};
      // Push one cycle after the last rise so rx_shift already holds the full word.
      push_pend <= last_bit;
      if (push_pend) begin
        if (!recv_val || recv_rdy) begin
          recv_msg <= rx_shift;
          recv_val <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (recv_rdy) begin
        recv_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_minion_frame_if.sv
// Directed bench for spi_minion_frame_if: table of full frames plus
// hand sequences for backpressure, abort, edge collision and reset.
module tb_spi_minion_frame_if;

  localparam int NB = 32;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          reset, cs, sclk, mosi, miso;
  logic [NB-1:0] recv_msg, send_msg;
  logic          recv_val, recv_rdy, send_val, send_rdy, overflow, underflow;

  spi_minion_frame_if #(.NBITS(NB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            srdy_cnt = 0;
  logic [NB-1:0] acc_q[$];
  logic [NB-1:0] miso_w;

  always @(negedge clk) begin
    if (send_rdy) srdy_cnt++;
    if (recv_val && recv_rdy) acc_q.push_back(recv_msg);
  end

  typedef struct {
    logic [NB-1:0] mosi_w;
    logic [NB-1:0] send_w;
    logic          send_v;
    logic [NB-1:0] exp_miso;
    logic          exp_uf;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic shift_bits(input logic [NB-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = w[NB-1-i];
      cyc(H);
      miso_w[NB-1-i] = miso;
      sclk = 1'b1;
      cyc(H);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [NB-1:0] w);
    miso_w = '0;
    cs = 1'b0;
    cyc(H);
    shift_bits(w, NB);
    cyc(H);
    cs = 1'b1;
    cyc(H);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
    vecs[1] = '{32'hA5A5A5A5, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
    vecs[2] = '{32'h00000001, 32'h80000001, 1'b1, 32'h80000001, 1'b0};
    vecs[3] = '{32'h13572468, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1};

    recv_rdy = 1'b0; send_msg = '0; send_val = 1'b0;
    do_reset();
    check("rst_miso", {31'd0, miso}, 0);
    check("rst_recv_val", {31'd0, recv_val}, 0);
    check("rst_recv_msg", recv_msg, 0);
    check("rst_send_rdy", {31'd0, send_rdy}, 0);
    check("rst_flags", {30'd0, overflow, underflow}, 0);

    recv_rdy = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_msg = vecs[v].send_w;
      send_val = vecs[v].send_v;
      srdy_cnt = 0;
      acc_q.delete();
      run_frame(vecs[v].mosi_w);
      send_val = 1'b0;
      check("vec_miso", miso_w, vecs[v].exp_miso);
      check("vec_recv_count", acc_q.size(), 1);
      if (acc_q.size() > 0) check("vec_recv_msg", acc_q[0], vecs[v].mosi_w);
      check("vec_send_rdy_cycles", srdy_cnt, {31'd0, vecs[v].send_v});
      check("vec_underflow", {31'd0, underflow}, {31'd0, vecs[v].exp_uf});
      check("vec_recv_val_cleared", {31'd0, recv_val}, 0);
    end

    // Abort after 17 rises, then a clean frame.
    send_msg = 32'hFFFFFFFF; send_val = 1'b1;
    acc_q.delete();
    cs = 1'b0;
    cyc(H);
    shift_bits(32'h5555AAAA, 17);
    cyc(H);
    cs = 1'b1;
    cyc(H);
    check("abort_no_push", acc_q.size(), 0);
    check("abort_recv_val", {31'd0, recv_val}, 0);
    check("abort_idle_miso", {31'd0, miso}, 0);
    run_frame(32'hA5A5A5A5);
    check("after_abort_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("after_abort_msg", acc_q[0], 32'hA5A5A5A5);

    // cs and the final sclk rise arrive together: abort must win.
    acc_q.delete();
    cs = 1'b0;
    cyc(H);
    shift_bits(32'hCAFEF00D, NB - 1);
    mosi = 1'b1;
    cyc(H);
    sclk = 1'b1; cs = 1'b1;
    cyc(H);
    sclk = 1'b0;
    cyc(H);
    check("collide_no_push", acc_q.size(), 0);
    check("collide_overflow", {31'd0, overflow}, 0);

    // Backpressure: second word is dropped.
    do_reset();
    recv_rdy = 1'b0;
    run_frame(32'h1);
    run_frame(32'h2);
    check("bp_recv_msg", recv_msg, 32'h1);
    check("bp_recv_val", {31'd0, recv_val}, 1);
    check("bp_overflow", {31'd0, overflow}, 1);
    recv_rdy = 1'b1;
    cyc(1);
    check("bp_val_drops", {31'd0, recv_val}, 0);

    // Accept and push in the same cycle.
    do_reset();
    recv_rdy = 1'b0;
    run_frame(32'h1);
    cs = 1'b0;
    cyc(H);
    shift_bits(32'h3, NB - 1);
    mosi = 1'b1;
    cyc(H);
    sclk = 1'b1;
    cyc(3);
    recv_rdy = 1'b1;
    cyc(1);
    recv_rdy = 1'b0;
    cyc(H);
    sclk = 1'b0;
    cyc(H);
    cs = 1'b1;
    cyc(H);
    check("simul_recv_msg", recv_msg, 32'h3);
    check("simul_recv_val", {31'd0, recv_val}, 1);
    check("simul_overflow", {31'd0, overflow}, 0);

    // Underflow set so the mid-frame reset has sticky state to clear.
    recv_rdy = 1'b1;
    send_val = 1'b0;
    run_frame(32'h7);
    send_msg = 32'hFFFFFFFF; send_val = 1'b1;
    acc_q.delete();
    cs = 1'b0;
    cyc(H);
    shift_bits(32'hF0F0F0F0, 10);
    reset = 1'b1; cs = 1'b1; sclk = 1'b0;
    cyc(2);
    check("midrst_recv_msg", recv_msg, 0);
    check("midrst_outs", {27'd0, miso, recv_val, send_rdy, overflow, underflow}, 0);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    acc_q.delete();
    run_frame(32'h0F0F0F0F);
    check("midrst_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("midrst_msg", acc_q[0], 32'h0F0F0F0F);
    check("midrst_miso", miso_w, 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
